// File: rtl/mat_mult_ctrl_pkg.sv
// Shared types and constants for the matrix-multiplier controller.
// State encoding plus default terminal indices for the reference config.
package mat_mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ACC,
    WRITE,
    STREAM
  } state_t;

  localparam int DEF_DW = 8;
  localparam int DEF_M  = 4;
  localparam int DEF_N  = 4;

  localparam logic [DEF_DW-1:0] M_LAST = DEF_DW'(DEF_M - 1);
  localparam logic [DEF_DW-1:0] N_LAST = DEF_DW'(DEF_N - 1);

  function automatic int lastIdx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/mat_idx_walker.sv
// 2-D index walker: counts the inner index and wraps it into the outer.
// Pure decode; the counters themselves live in the datapath.
module mat_idx_walker
  import mat_mult_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          advance,
  input  logic [DW-1:0] innerVal,
  input  logic [DW-1:0] outerVal,
  input  logic [DW-1:0] innerLast,
  input  logic [DW-1:0] outerLast,
  output logic          innerCountEn,
  output logic          innerZero,
  output logic          outerCountEn,
  output logic          outerZero,
  output logic          wrap,
  output logic          last
);

  logic innerEnd;
  logic outerEnd;

  assign innerEnd = (innerVal == innerLast);
  assign outerEnd = (outerVal == outerLast);

  assign wrap = innerEnd;
  assign last = innerEnd && outerEnd;

  assign innerCountEn = advance && !innerEnd;
  assign innerZero    = advance && innerEnd;
  assign outerCountEn = advance && innerEnd && !outerEnd;
  assign outerZero    = advance && last;

endmodule

// File: rtl/mat_mult_ctrl.sv
// Control FSM for the matrix-multiplier datapath: load A, load B,
// accumulate C = A*B element by element, then stream C out.
module mat_mult_ctrl
  import mat_mult_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int M  = 4,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inValid,
  output logic          inReady,
  input  logic          outReady,
  output logic          outValid,
  output logic          busy,
  output logic          done,
  output logic          ovfFlag,
  input  logic          overflow,
  input  logic [DW-1:0] mCounter1Value,
  input  logic [DW-1:0] nCounter1Value,
  input  logic [DW-1:0] mCounter2Value,
  input  logic [DW-1:0] nCounter2Value,
  input  logic [DW-1:0] resRowCounterValue,
  input  logic [DW-1:0] resColCounterValue,
  output logic          matrix1WriteEn,
  output logic          matrix2WriteEn,
  output logic          resMatrixWriteEn,
  output logic          sumRegWriteEn,
  output logic          sumRegZero,
  output logic          mCounter1CountEn,
  output logic          mCounter1Zero,
  output logic          nCounter1CountEn,
  output logic          nCounter1Zero,
  output logic          mCounter2CountEn,
  output logic          mCounter2Zero,
  output logic          nCounter2CountEn,
  output logic          nCounter2Zero,
  output logic          resRowCounterCountEn,
  output logic          resRowCounterZero,
  output logic          resColCounterCountEn,
  output logic          resColCounterZero
);

  localparam logic [DW-1:0] mLast = DW'(lastIdx(M));
  localparam logic [DW-1:0] nLast = DW'(lastIdx(N));

  state_t state;
  state_t stateNxt;
  logic   ovfReg;
  logic   ovfNxt;

  logic aAdv, aInCe, aInZ, aOutCe, aOutZ, aWrap, aLast;
  logic bAdv, bInCe, bInZ, bOutCe, bOutZ, bWrap, bLast;
  logic rAdv, rInCe, rInZ, rOutCe, rOutZ, rWrap, rLast;
  logic kEnd;
  logic unusedWraps;

  assign aAdv = (state == LOAD_A) && inValid;
  assign bAdv = (state == LOAD_B) && inValid;
  assign rAdv = (state == WRITE) ||
                ((state == STREAM) && outReady);
  assign kEnd = (nCounter1Value == nLast);

  assign unusedWraps = aWrap ^ bWrap ^ rWrap;

  // A is row-major: column index n1 is the inner loop.
  mat_idx_walker #(.DW(DW)) walkA (
    .advance      (aAdv),
    .innerVal     (nCounter1Value),
    .outerVal     (mCounter1Value),
    .innerLast    (nLast),
    .outerLast    (mLast),
    .innerCountEn (aInCe),
    .innerZero    (aInZ),
    .outerCountEn (aOutCe),
    .outerZero    (aOutZ),
    .wrap         (aWrap),
    .last         (aLast)
  );

  // B is row-major too: column index m2 is the inner loop.
  mat_idx_walker #(.DW(DW)) walkB (
    .advance      (bAdv),
    .innerVal     (mCounter2Value),
    .outerVal     (nCounter2Value),
    .innerLast    (mLast),
    .outerLast    (nLast),
    .innerCountEn (bInCe),
    .innerZero    (bInZ),
    .outerCountEn (bOutCe),
    .outerZero    (bOutZ),
    .wrap         (bWrap),
    .last         (bLast)
  );

  mat_idx_walker #(.DW(DW)) walkR (
    .advance      (rAdv),
    .innerVal     (resColCounterValue),
    .outerVal     (resRowCounterValue),
    .innerLast    (mLast),
    .outerLast    (mLast),
    .innerCountEn (rInCe),
    .innerZero    (rInZ),
    .outerCountEn (rOutCe),
    .outerZero    (rOutZ),
    .wrap         (rWrap),
    .last         (rLast)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ovfReg <= 1'b0;
    end else begin
      state  <= stateNxt;
      ovfReg <= ovfNxt;
    end
  end

  assign busy    = (state != IDLE);
  assign ovfFlag = ovfReg;

  always_comb begin
    stateNxt             = state;
    ovfNxt               = ovfReg;
    inReady              = 1'b0;
    outValid             = 1'b0;
    done                 = 1'b0;
    matrix1WriteEn       = 1'b0;
    matrix2WriteEn       = 1'b0;
    resMatrixWriteEn     = 1'b0;
    sumRegWriteEn        = 1'b0;
    sumRegZero           = 1'b0;
    mCounter1CountEn     = 1'b0;
    mCounter1Zero        = 1'b0;
    nCounter1CountEn     = 1'b0;
    nCounter1Zero        = 1'b0;
    mCounter2CountEn     = 1'b0;
    mCounter2Zero        = 1'b0;
    nCounter2CountEn     = 1'b0;
    nCounter2Zero        = 1'b0;
    resRowCounterCountEn = 1'b0;
    resRowCounterZero    = 1'b0;
    resColCounterCountEn = 1'b0;
    resColCounterZero    = 1'b0;
    unique case (state)
      IDLE: begin
        // rst gates the idle strobes so reset forces every output low.
        sumRegZero        = rst;
        mCounter1Zero     = rst;
        nCounter1Zero     = rst;
        mCounter2Zero     = rst;
        nCounter2Zero     = rst;
        resRowCounterZero = rst;
        resColCounterZero = rst;
        if (start) begin
          stateNxt = LOAD_A;
          ovfNxt   = 1'b0;
        end
      end
      LOAD_A: begin
        inReady          = 1'b1;
        matrix1WriteEn   = inValid;
        nCounter1CountEn = aInCe;
        nCounter1Zero    = aInZ;
        mCounter1CountEn = aOutCe;
        mCounter1Zero    = aOutZ;
        if (aAdv && aLast) begin
          stateNxt = LOAD_B;
        end
      end
      LOAD_B: begin
        inReady          = 1'b1;
        matrix2WriteEn   = inValid;
        mCounter2CountEn = bInCe;
        mCounter2Zero    = bInZ;
        nCounter2CountEn = bOutCe;
        nCounter2Zero    = bOutZ;
        if (bAdv && bLast) begin
          stateNxt = ACC;
        end
      end
      ACC: begin
        sumRegWriteEn = 1'b1;
        if (kEnd) begin
          nCounter1Zero = 1'b1;
          nCounter2Zero = 1'b1;
          stateNxt      = WRITE;
        end else begin
          nCounter1CountEn = 1'b1;
          nCounter2CountEn = 1'b1;
        end
      end
      WRITE: begin
        // Result counters track (i,j); m1/m2 follow them in lockstep.
        resMatrixWriteEn     = 1'b1;
        sumRegZero           = 1'b1;
        resColCounterCountEn = rInCe;
        resColCounterZero    = rInZ;
        resRowCounterCountEn = rOutCe;
        resRowCounterZero    = rOutZ;
        mCounter2CountEn     = rInCe;
        mCounter2Zero        = rInZ;
        mCounter1CountEn     = rOutCe;
        mCounter1Zero        = rOutZ;
        stateNxt             = rLast ? STREAM : ACC;
      end
      STREAM: begin
        outValid             = 1'b1;
        resColCounterCountEn = rInCe;
        resColCounterZero    = rInZ;
        resRowCounterCountEn = rOutCe;
        resRowCounterZero    = rOutZ;
        if (outReady) begin
          ovfNxt = ovfReg | overflow;
          if (rLast) begin
            done     = 1'b1;
            stateNxt = IDLE;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule
